rx_fc_credit_return: RTL and testbench

Receive-side flow-control credit return for VC0, sitting directly downstream of the six VC0 receive buffers (PH, PD, NPH, NPD, CH, CD). It counts credits freed as the transaction layer drains each buffer, runs the InitFC1/InitFC2 handshake after link-up, and then emits UpdateFC DLLPs toward the data-link transmit arbiter over a valid/ready interface.

---
 rtl/rx_fc_credit_return.sv | 185 ++++++++++++++++++
 tb/tb_rx_fc_credit_return.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_fc_credit_return.sv
// VC0 receive credit counters, InitFC1/InitFC2 handshake and UpdateFC source; DLLP loads one cycle after a freed credit.
// Output is held under dllp_ready backpressure; optional FC_PERIODIC_UPDATE_EN re-advertises every class each TIMER_PERIOD cycles.
module rx_fc_credit_return #(
   parameter int PH_INIT      = 16,
   parameter int PD_INIT      = 16,
   parameter int NPH_INIT     = 16,
   parameter int NPD_INIT     = 16,
   parameter int CH_INIT      = 16,
   parameter int CD_INIT      = 16,
   parameter int TIMER_PERIOD = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        link_up,
   input  logic        ph_rd_en,
   input  logic        pd_rd_en,
   input  logic        nph_rd_en,
   input  logic        npd_rd_en,
   input  logic        ch_rd_en,
   input  logic        cd_rd_en,
   output logic        dllp_valid,
   input  logic        dllp_ready,
   output logic [31:0] dllp_data,
   output logic        fc_init_done
);

   typedef enum logic [1:0] {INIT1, INIT2, ACTIVE} state_t;

   localparam logic [1:0] CLS_P      = 2'd0;
   localparam logic [1:0] CLS_CPL    = 2'd2;
   localparam logic [1:0] KIND_INIT1 = 2'd0;
   localparam logic [1:0] KIND_INIT2 = 2'd1;
   localparam logic [1:0] KIND_UPD   = 2'd2;

   state_t      state;
   logic [1:0]  idx;
   logic [1:0]  last;
   logic [2:0]  pend;
   logic [2:0]  inc;
   logic [2:0]  pend_set;
   logic [2:0]  rr_clr;
   logic [7:0]  ph_cnt, nph_cnt, ch_cnt;
   logic [11:0] pd_cnt, npd_cnt, cd_cnt;
   logic [7:0]  hdr_of [3];
   logic [11:0] dat_of [3];
   logic [1:0]  c1, c2, rr_pick, idx_nxt, init_kind;
   logic        rr_any, can_load, tmr_tc;

   function automatic logic [1:0] nxt_cls(input logic [1:0] c);
      return (c == CLS_CPL) ? CLS_P : c + 2'd1;
   endfunction

   function automatic logic [7:0] fc_type(input logic [1:0] kind, input logic [1:0] cls);
      logic [7:0] base;
      case (kind)
         KIND_INIT1: base = 8'h40;
         KIND_INIT2: base = 8'hC0;
         default:    base = 8'h80;
      endcase
      return base + {2'b00, cls, 4'b0000};
   endfunction

   function automatic logic [31:0] mk(input logic [7:0] typ, input logic [7:0] hdr, input logic [11:0] dat);
      return {typ, 2'b00, hdr, 2'b00, dat};
   endfunction

   // Class index: 0 = posted, 1 = non-posted, 2 = completion.
   assign inc = {ch_rd_en | cd_rd_en, nph_rd_en | npd_rd_en, ph_rd_en | pd_rd_en};
   assign pend_set = inc | {3{tmr_tc}};

   assign hdr_of[0] = ph_cnt;
   assign hdr_of[1] = nph_cnt;
   assign hdr_of[2] = ch_cnt;
   assign dat_of[0] = pd_cnt;
   assign dat_of[1] = npd_cnt;
   assign dat_of[2] = cd_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_cnt  <= 8'(PH_INIT);
         pd_cnt  <= 12'(PD_INIT);
         nph_cnt <= 8'(NPH_INIT);
         npd_cnt <= 12'(NPD_INIT);
         ch_cnt  <= 8'(CH_INIT);
         cd_cnt  <= 12'(CD_INIT);
      end else begin
         ph_cnt  <= ph_cnt  + 8'(ph_rd_en);
         pd_cnt  <= pd_cnt  + 12'(pd_rd_en);
         nph_cnt <= nph_cnt + 8'(nph_rd_en);
         npd_cnt <= npd_cnt + 12'(npd_rd_en);
         ch_cnt  <= ch_cnt  + 8'(ch_rd_en);
         cd_cnt  <= cd_cnt  + 12'(cd_rd_en);
      end
   end

   // Round-robin pick starting after the last class sent.
   always_comb begin
      c1        = nxt_cls(last);
      c2        = nxt_cls(c1);
      rr_any    = |pend;
      if (pend[c1])      rr_pick = c1;
      else if (pend[c2]) rr_pick = c2;
      else               rr_pick = last;
      can_load  = !dllp_valid || dllp_ready;
      rr_clr    = 3'b000;
      if (state == ACTIVE && can_load && rr_any) rr_clr[rr_pick] = 1'b1;
      init_kind = (state == INIT1) ? KIND_INIT1 : KIND_INIT2;
      idx_nxt   = idx + 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= INIT1;
         idx          <= CLS_P;
         last         <= CLS_CPL;
         pend         <= 3'b000;
         dllp_valid   <= 1'b0;
         dllp_data    <= 32'h0;
         fc_init_done <= 1'b0;
      end else if (!link_up) begin
         state        <= INIT1;
         idx          <= CLS_P;
         pend         <= 3'b000;
         dllp_valid   <= 1'b0;
         fc_init_done <= 1'b0;
      end else begin
         case (state)
            INIT1, INIT2: begin
               pend <= pend | inc;
               if (!dllp_valid) begin
                  dllp_valid <= 1'b1;
                  dllp_data  <= mk(fc_type(init_kind, idx), hdr_of[idx], dat_of[idx]);
               end else if (dllp_ready) begin
                  if (idx != CLS_CPL) begin
                     idx       <= idx_nxt;
                     dllp_data <= mk(fc_type(init_kind, idx_nxt), hdr_of[idx_nxt], dat_of[idx_nxt]);
                  end else if (state == INIT1) begin
                     state     <= INIT2;
                     idx       <= CLS_P;
                     dllp_data <= mk(fc_type(KIND_INIT2, CLS_P), hdr_of[CLS_P], dat_of[CLS_P]);
                  end else begin
                     // Credits freed on the entry edge itself still need advertising.
                     state        <= ACTIVE;
                     idx          <= CLS_P;
                     dllp_valid   <= 1'b0;
                     fc_init_done <= 1'b1;
                     pend         <= inc;
                  end
               end
            end
            default: begin
               pend <= (pend & ~rr_clr) | pend_set;
               if (can_load) begin
                  dllp_valid <= rr_any;
                  if (rr_any) begin
                     dllp_data <= mk(fc_type(KIND_UPD, rr_pick), hdr_of[rr_pick], dat_of[rr_pick]);
                     last      <= rr_pick;
                  end
               end
            end
         endcase
      end
   end

`ifdef FC_PERIODIC_UPDATE_EN
   localparam int TW = (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;
   logic [TW-1:0] tmr;

   assign tmr_tc = (state == ACTIVE) && (tmr == TW'(TIMER_PERIOD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr <= '0;
      end else if (!link_up || state != ACTIVE || tmr_tc) begin
         tmr <= '0;
      end else begin
         tmr <= tmr + TW'(1);
      end
   end
`else
   // No timer built: never fires; TIMER_PERIOD is only meaningful with the timer.
   assign tmr_tc = (TIMER_PERIOD < 0);
`endif

endmodule

// File: tb/tb_rx_fc_credit_return.sv
// Directed bench for rx_fc_credit_return: per-cycle vector table for init and UpdateFC
// ordering/backpressure, then sequences for periodic update, async reset, counter wrap and link drop.
module tb_rx_fc_credit_return;

   logic        clk;
   logic        rst_n;
   logic        link_up;
   logic        ph_rd_en, pd_rd_en, nph_rd_en, npd_rd_en, ch_rd_en, cd_rd_en;
   logic        dllp_valid;
   logic        dllp_ready;
   logic [31:0] dllp_data;
   logic        fc_init_done;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [31:0] got_q [$];
   int          cyc_q [$];
   logic [31:0] last_np;
   logic [31:0] per_exp [3];
   int          wait_n;

   typedef struct packed {
      logic        link;
      logic        rdy;
      logic [5:0]  rd;    // {ph, pd, nph, npd, ch, cd}
      logic        ev;
      logic        ed;
      logic [31:0] dat;
   } vec_t;

   vec_t tbl [29];

   rx_fc_credit_return #(
      .PH_INIT(16), .PD_INIT(16), .NPH_INIT(16), .NPD_INIT(16), .CH_INIT(16), .CD_INIT(16),
      .TIMER_PERIOD(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .link_up(link_up),
      .ph_rd_en(ph_rd_en), .pd_rd_en(pd_rd_en), .nph_rd_en(nph_rd_en),
      .npd_rd_en(npd_rd_en), .ch_rd_en(ch_rd_en), .cd_rd_en(cd_rd_en),
      .dllp_valid(dllp_valid), .dllp_ready(dllp_ready), .dllp_data(dllp_data),
      .fc_init_done(fc_init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Inputs only change just after a rising edge, so mid-cycle values show the coming handshake.
   always @(negedge clk) begin
      if (rst_n && link_up && dllp_valid && dllp_ready) begin
         got_q.push_back(dllp_data);
         cyc_q.push_back(cyc);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_rd(input logic [5:0] v);
      {ph_rd_en, pd_rd_en, nph_rd_en, npd_rd_en, ch_rd_en, cd_rd_en} = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           link  rdy   rd          ev    ed    data
      tbl[ 0] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b0, 32'h40040010};
      tbl[ 1] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b0, 32'h50040010};
      tbl[ 2] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b0, 32'h60040010};
      tbl[ 3] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b0, 32'hC0040010};
      tbl[ 4] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b0, 32'hD0040010};
      tbl[ 5] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b0, 32'hE0040010};
      tbl[ 6] = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b1, 32'h0};
      tbl[ 7] = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b1, 32'h0};
      // 3 x ph + 2 x pd: final snapshot hdr 19, data 18
      tbl[ 8] = '{1'b1, 1'b1, 6'b110000, 1'b0, 1'b1, 32'h0};
      tbl[ 9] = '{1'b1, 1'b1, 6'b110000, 1'b1, 1'b1, 32'h80044011};
      tbl[10] = '{1'b1, 1'b1, 6'b100000, 1'b1, 1'b1, 32'h80048012};
      tbl[11] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b1, 32'h8004C012};
      tbl[12] = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b1, 32'h0};
      tbl[13] = '{1'b1, 1'b1, 6'b000001, 1'b0, 1'b1, 32'h0};
      tbl[14] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b1, 32'hA0040011};
      tbl[15] = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b1, 32'h0};
      // ph, nph, cd together after Cpl was last: P, NP, Cpl back to back
      tbl[16] = '{1'b1, 1'b1, 6'b101001, 1'b0, 1'b1, 32'h0};
      tbl[17] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b1, 32'h80050012};
      tbl[18] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b1, 32'h90044010};
      tbl[19] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b1, 32'hA0040012};
      tbl[20] = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b1, 32'h0};
      // backpressure: snapshot held, second UpdateFC P carries the later count
      tbl[21] = '{1'b1, 1'b0, 6'b100000, 1'b0, 1'b1, 32'h0};
      tbl[22] = '{1'b1, 1'b0, 6'b100000, 1'b1, 1'b1, 32'h80054012};
      tbl[23] = '{1'b1, 1'b0, 6'b100000, 1'b1, 1'b1, 32'h80054012};
      tbl[24] = '{1'b1, 1'b0, 6'b100000, 1'b1, 1'b1, 32'h80054012};
      tbl[25] = '{1'b1, 1'b0, 6'b000000, 1'b1, 1'b1, 32'h80054012};
      tbl[26] = '{1'b1, 1'b0, 6'b000000, 1'b1, 1'b1, 32'h80054012};
      tbl[27] = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b1, 32'h80060012};
      tbl[28] = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b1, 32'h0};

      rst_n      = 1'b0;
      link_up    = 1'b1;
      dllp_ready = 1'b1;
      set_rd(6'b000000);
      tick();
      tick();
      check("reset valid", 32'(dllp_valid), 32'd0);
      check("reset data", dllp_data, 32'h0);
      check("reset init_done", 32'(fc_init_done), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 29; i++) begin
         link_up    = tbl[i].link;
         dllp_ready = tbl[i].rdy;
         set_rd(tbl[i].rd);
         tick();
         check($sformatf("vec%0d valid", i), 32'(dllp_valid), 32'(tbl[i].ev));
         check($sformatf("vec%0d init_done", i), 32'(fc_init_done), 32'(tbl[i].ed));
         if (tbl[i].ev) check($sformatf("vec%0d data", i), dllp_data, tbl[i].dat);
      end

      // Idle ACTIVE: periodic rounds only when the timer is built (last sent class was P).
      got_q.delete();
      cyc_q.delete();
      repeat (50) tick();
`ifdef FC_PERIODIC_UPDATE_EN
      per_exp[0] = 32'h90044010;
      per_exp[1] = 32'hA0040012;
      per_exp[2] = 32'h80060012;
      check("periodic dllp count", 32'(got_q.size()), 32'd6);
      if (got_q.size() == 6) begin
         for (int k = 0; k < 6; k++) check($sformatf("periodic dllp%0d", k), got_q[k], per_exp[k % 3]);
         check("periodic spacing", 32'(cyc_q[3] - cyc_q[0]), 32'd32);
         check("periodic back-to-back", 32'(cyc_q[2] - cyc_q[0]), 32'd2);
      end
`else
      check("no output when idle", 32'(got_q.size()), 32'd0);
`endif

      // Async reset while a DLLP is held.
      dllp_ready = 1'b0;
      set_rd(6'b100000);
      tick();
      set_rd(6'b000000);
      tick();
      check("held before reset", 32'(dllp_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async reset valid", 32'(dllp_valid), 32'd0);
      check("async reset data", dllp_data, 32'h0);
      check("async reset init_done", 32'(fc_init_done), 32'd0);
      tick();
      got_q.delete();
      rst_n      = 1'b1;
      dllp_ready = 1'b1;
      wait_n     = 0;
      while (!fc_init_done && wait_n < 20) begin
         tick();
         wait_n++;
      end
      check("init_done after reset", 32'(fc_init_done), 32'd1);
      check("init dllp count after reset", 32'(got_q.size()), 32'd6);
      if (got_q.size() == 6) begin
         check("InitFC1 P after reset", got_q[0], 32'h40040010);
         check("InitFC1 NP after reset", got_q[1], 32'h50040010);
         check("InitFC2 Cpl after reset", got_q[5], 32'hE0040010);
      end

      // 300 non-posted header frees: 16 + 300 wraps to 60.
      set_rd(6'b001000);
      repeat (300) tick();
      set_rd(6'b000000);
      repeat (10) tick();
      last_np = 32'h0;
      foreach (got_q[k]) if (got_q[k][31:24] == 8'h90) last_np = got_q[k];
      check("nph wrap", last_np, 32'h900F0010);

      // Link drop while a DLLP is held, then InitFC1 restarts with kept counters.
      dllp_ready = 1'b0;
      set_rd(6'b100000);
      tick();
      set_rd(6'b000000);
      tick();
      check("held before link drop", 32'(dllp_valid), 32'd1);
      link_up = 1'b0;
      tick();
      check("link drop valid", 32'(dllp_valid), 32'd0);
      check("link drop init_done", 32'(fc_init_done), 32'd0);
      repeat (3) tick();
      check("link down stays idle", 32'(dllp_valid), 32'd0);
      link_up    = 1'b1;
      dllp_ready = 1'b1;
      tick();
      check("relink valid", 32'(dllp_valid), 32'd1);
      check("relink InitFC1 P", dllp_data, 32'h40044010);
      repeat (5) tick();
      check("relink init_done early", 32'(fc_init_done), 32'd0);
      tick();
      check("relink init_done", 32'(fc_init_done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
